// File: rtl/clk_div_mon_pkg.sv
// clk_div_mon_pkg
// Shared definitions for the divided-clock monitor: the measurement FSM
// state type and the default counter width / lock depth.
package clk_div_mon_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned LOCK_N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_monitor_edge_det.sv
// edge_det
// Registers a signal that is already synchronous to clk and flags its edges
// in the cycle they first appear at the input.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   sig  - monitored signal
//   rise - sig high now, low last cycle
//   fall - sig low now, high last cycle
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= sig;
    end

    assign rise = sig & ~d_q;
    assign fall = ~sig & d_q;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Measures the period and high phase of a divided clock generated from clk,
// compares each complete period with exp_div and declares lock after LOCK_N
// consecutive matches. A phase that never ends raises a timeout error.
// Optional feature macro: CLK_DIV_MON_DUTY_EN enables the duty-cycle check;
// without it duty_err is tied low.
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset
//   div_clk    - divided clock under test (synchronous to clk)
//   exp_div    - expected division ratio (2 .. 2^CNT_W-1)
//   period     - last measured period in clk cycles
//   high_cnt   - high-phase length of last period
//   meas_valid - one-cycle pulse when period/high_cnt update
//   locked     - LOCK_N consecutive periods equal to exp_div
//   err        - one-cycle pulse on period mismatch or timeout
//   duty_err   - one-cycle pulse on duty violation
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned LOCK_N = LOCK_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic [CNT_W-1:0] exp_div,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             duty_err
);

    localparam int unsigned MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A counter sitting here with its phase still running reaches CNT_MAX
    // on this edge, which is the timeout point.
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_next;
    logic [CNT_W:0]   sum_full;
    logic [CNT_W-1:0] sum_sat;
    logic             match;

    edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (div_clk),
        .rise (rise),
        .fall (fall)
    );

    assign sum_full   = {1'b0, hcnt} + {1'b0, lcnt};
    assign sum_sat    = sum_full[CNT_W] ? CNT_MAX : sum_full[CNT_W-1:0];
    assign match      = (sum_sat == exp_div);
    assign match_next = (match_cnt == LOCK_V) ? match_cnt : match_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            lcnt       <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    // Period started from IDLE is measured but the rise
                    // that opens it reports nothing.
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        lcnt  <= CNT_ONE;
                    end else if (hcnt >= CNT_TO) begin
                        hcnt      <= CNT_MAX;
                        err       <= 1'b1;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state      <= HIGH;
                        hcnt       <= CNT_ONE;
                        period     <= sum_sat;
                        high_cnt   <= hcnt;
                        meas_valid <= 1'b1;
                        if (match) begin
                            match_cnt <= match_next;
                            locked    <= (match_next == LOCK_V);
                        end else begin
                            err       <= 1'b1;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end else if (lcnt >= CNT_TO) begin
                        lcnt      <= CNT_MAX;
                        err       <= 1'b1;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLK_DIV_MON_DUTY_EN
    localparam logic [CNT_W:0] ONE_W = (CNT_W + 1)'(1);
    logic [CNT_W-1:0] low_len;
    logic             duty_bad;

    // Low phase taken from the reported (saturated) period so the check is
    // consistent with what period/high_cnt show.
    assign low_len  = sum_sat - hcnt;
    assign duty_bad = ({1'b0, hcnt} > ({1'b0, low_len} + ONE_W)) ||
                      ({1'b0, low_len} > ({1'b0, hcnt} + ONE_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) duty_err <= 1'b0;
        else      duty_err <= (state == LOW) && rise && duty_bad;
    end
`else
    assign duty_err = 1'b0;
`endif

endmodule
